// File: rtl/layer_pkg.sv
// Shared definitions for the compositor layers: pixel color type, screen
// geometry and the 6-bit-index to RGB444 palette.
package layer_pkg;

  typedef logic [11:0] rgb_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  // Raster coordinate width, wide enough for either screen dimension.
  localparam int COORD_W  = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);
  localparam int IDX_W    = 6;

  // 64-entry palette: each 2-bit channel field is replicated into 4 bits,
  // so 0..3 maps onto the evenly spaced levels 0x0, 0x5, 0xA, 0xF.
  function automatic rgb_t palette_lookup(input logic [IDX_W-1:0] idx);
    return {idx[5:4], idx[5:4], idx[3:2], idx[3:2], idx[1:0], idx[1:0]};
  endfunction

endpackage

// File: rtl/layer_sprite_if.sv
// Raster, configuration and pixel-output bundle of the sprite layer.
// SPRITE_FLIP_EN adds the flip_h control.
interface layer_sprite_if;
  import layer_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               vsync_pulse;
  logic               cfg_we;
  logic [COORD_W-1:0] cfg_x;
  logic [COORD_W-1:0] cfg_y;
  logic               anim_en;
`ifdef SPRITE_FLIP_EN
  logic               flip_h;
`endif
  rgb_t               color;
  logic               opaque;

  modport master (
    output DrawX, DrawY, vsync_pulse, cfg_we, cfg_x, cfg_y, anim_en,
`ifdef SPRITE_FLIP_EN
    output flip_h,
`endif
    input  color, opaque
  );

  modport slave (
    input  DrawX, DrawY, vsync_pulse, cfg_we, cfg_x, cfg_y, anim_en,
`ifdef SPRITE_FLIP_EN
    input  flip_h,
`endif
    output color, opaque
  );

endinterface

// File: rtl/rom_sprite.sv
// Sprite art store: palette indices for every animation frame, preloaded
// from sprite.mif. Synchronous read. The write port lets a host refresh the
// art at run time; the sprite layer ties it off so it builds as a ROM.
module rom_sprite #(
  parameter int DEPTH = 128000,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [IDX_W-1:0]         rd_q,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [IDX_W-1:0]         wr_data
);

  (* ram_init_file = "sprite.mif" *) logic [IDX_W-1:0] mem [DEPTH];

  // Registered read plus optional update write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[addr];
  end

endmodule

// File: rtl/layer_sprite.sv
// Sprite layer: windows the raster against a double-buffered position,
// addresses the multi-frame sprite ROM, animates frames every FRAME_DIV
// vsyncs and emits a palette color plus opaque flag three cycles later.
// Optional feature macro: SPRITE_FLIP_EN (horizontal mirroring via flip_h).
module layer_sprite
  import layer_pkg::*;
#(
  parameter int X_SIZE     = 160,
  parameter int Y_SIZE     = 200,
  parameter int FRAMES     = 4,
  parameter int FRAME_DIV  = 8,
  parameter int TRANSP_IDX = 0
) (
  input  logic          pixel_clk,
  input  logic          Reset,
  layer_sprite_if.slave bus
);

  localparam int FRAME_WORDS = X_SIZE * Y_SIZE;
  localparam int DEPTH       = FRAMES * FRAME_WORDS;
  localparam int ADDR_W      = $clog2(DEPTH);
  localparam int FRAME_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  // One extra bit so left edge + size never wraps: clipped, not wrapped.
  localparam int CW          = COORD_W + 1;

  logic [COORD_W-1:0] sh_x_d, sh_x_q, sh_y_d, sh_y_q;
  logic [COORD_W-1:0] act_x_d, act_x_q, act_y_d, act_y_q;
  logic [FRAME_W-1:0] frame_d, frame_q;
  logic [DIV_W-1:0]   div_d, div_q;
`ifdef SPRITE_FLIP_EN
  logic               flip_d, flip_q;
`endif
  logic [CW-1:0]      dx, dy, ax, ay, lx, ly;
  logic               in_win;
  logic [ADDR_W-1:0]  addr_p0_d, addr_p0_q;
  logic               vld_p0_d, vld_p0_q, vld_p1_q;
  logic [IDX_W-1:0]   idx_p1;
  rgb_t               color_p2_d, color_p2_q;
  logic               opaque_p2_d, opaque_p2_q;

  // Shadow/active position (write-through on a shared cycle) and animation
  always_comb begin
    sh_x_d  = bus.cfg_we ? bus.cfg_x : sh_x_q;
    sh_y_d  = bus.cfg_we ? bus.cfg_y : sh_y_q;
    act_x_d = act_x_q;
    act_y_d = act_y_q;
    frame_d = frame_q;
    div_d   = div_q;
`ifdef SPRITE_FLIP_EN
    flip_d  = bus.vsync_pulse ? bus.flip_h : flip_q;
`endif
    if (bus.vsync_pulse) begin
      act_x_d = sh_x_d;
      act_y_d = sh_y_d;
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d = '0;
        if (bus.anim_en)
          frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Window test and ROM address for the current raster pixel
  always_comb begin
    dx     = {1'b0, bus.DrawX};
    dy     = {1'b0, bus.DrawY};
    ax     = {1'b0, act_x_q};
    ay     = {1'b0, act_y_q};
    in_win = (dx >= ax) && (dx < ax + CW'(X_SIZE)) &&
             (dy >= ay) && (dy < ay + CW'(Y_SIZE));
    lx     = dx - ax;
`ifdef SPRITE_FLIP_EN
    if (flip_q) lx = CW'(X_SIZE - 1) - lx;
`endif
    ly     = dy - ay;
    addr_p0_d = '0;
    if (in_win)
      addr_p0_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_WORDS) +
                  ADDR_W'(ly) * ADDR_W'(X_SIZE) + ADDR_W'(lx);
    vld_p0_d = in_win;
  end

  // Palette stage: transparent index or out-of-window pixels go black
  always_comb begin
    opaque_p2_d = vld_p1_q && (idx_p1 != IDX_W'(TRANSP_IDX));
    color_p2_d  = opaque_p2_d ? palette_lookup(idx_p1) : '0;
  end

  // Control state, per-stage valid flags and output registers
  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      frame_q     <= '0;
      div_q       <= '0;
`ifdef SPRITE_FLIP_EN
      flip_q      <= 1'b0;
`endif
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      color_p2_q  <= '0;
      opaque_p2_q <= 1'b0;
    end else begin
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      frame_q     <= frame_d;
      div_q       <= div_d;
`ifdef SPRITE_FLIP_EN
      flip_q      <= flip_d;
`endif
      // S0 -> S1: flag follows the ROM read
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p0_q;
      // S1 -> S2: palette result
      color_p2_q  <= color_p2_d;
      opaque_p2_q <= opaque_p2_d;
    end
  end

  // S0 address register (data path, not reset)
  always_ff @(posedge pixel_clk) begin
    addr_p0_q <= addr_p0_d;
  end

  rom_sprite #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_rom (
    .clk     (pixel_clk),
    .addr    (addr_p0_q),
    .rd_q    (idx_p1),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_data ('0)
  );

  assign bus.color  = color_p2_q;
  assign bus.opaque = opaque_p2_q;

endmodule

// File: doc/layer_sprite.md
# layer_sprite

Parametrised, pipelined sprite layer for the VGA compositor: one rectangular sprite of configurable size, with a multi-frame sprite ROM, a run-time screen position, automatic frame animation and a transparency output. It sits between the DrawX/DrawY raster counters and the layer priority mux. It outputs a 12-bit RGB color and an opaque flag per pixel. Position updates are double-buffered and only take effect at frame start, so the sprite never tears mid-frame.

## Interface
- X_SIZE, 160, sprite width in pixels
- Y_SIZE, 200, sprite height in pixels
- FRAMES, 4, animation frames stored back-to-back in ROM (power of two)
- FRAME_DIV, 8, vsync pulses per animation step (≥1)
- TRANSP_IDX, 0, palette index treated as transparent
- pixel_clk  in  1  pixel clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- vsync_pulse  in  1  one-cycle strobe at frame start
- cfg_we  in  1  write strobe for position shadow registers
- cfg_x  in  10  new sprite left edge
- cfg_y  in  10  new sprite top edge
- anim_en  in  1  enables frame advance
- color  out  12  RGB444 pixel color
- opaque  out  1  1 when color is a visible sprite pixel

## Operation
- Shadow regs sh_x/sh_y load cfg_x/cfg_y on cfg_we. Active regs act_x/act_y copy the shadow on vsync_pulse.
- If cfg_we and vsync_pulse occur in the same cycle, active takes the new cfg value (write-through).
- Window test: 11-bit compares, DrawX ≥ act_x and DrawX < act_x+X_SIZE, and the same for Y with Y_SIZE. Sprites that extend past the screen edge are clipped, not wrapped.
- Local coordinates: lx = DrawX−act_x, ly = DrawY−act_y.
- ROM address = frame·X_SIZE·Y_SIZE + ly·X_SIZE + lx. Width is ADDR_W = $clog2(FRAMES·X_SIZE·Y_SIZE).
- Animation:
  - div counter increments on each vsync_pulse.
  - When div = FRAME_DIV−1 it wraps to 0. If anim_en=1, frame increments modulo FRAMES.
  - If anim_en=0, frame holds, but div keeps counting.
- Pipeline, one valid bit per stage:
  - S0 registers address and the in-window flag.
  - S1 performs the synchronous ROM read; the flag is delayed alongside it.
  - S2 does the palette lookup and registers color/opaque.
- opaque = in-window AND index ≠ TRANSP_IDX. When opaque=0, color = 12'h000.
- Reset clears: sh/act positions, frame, div, all pipeline flags, color and opaque, all to 0. ROM contents are unaffected.
- A Reset asserted mid-line forces opaque=0 from the next edge onward.

## Timing
- Latency is 3 pixel_clk cycles from DrawX/DrawY to color/opaque. Throughput is one pixel per cycle; there are no stalls.
- An active position change is visible to window tests beginning the cycle after the vsync_pulse edge.
- A frame change is visible in the ROM address the cycle after the vsync_pulse edge that causes it.
- Outputs are fully registered, so there is no combinational path from inputs to outputs.

## Configuration
- SPRITE_FLIP_EN defined:
  - Adds input port flip_h (1 bit), latched into the active registers at vsync_pulse alongside position.
  - When set, lx becomes X_SIZE−1−(DrawX−act_x), mirroring the sprite horizontally.
- SPRITE_FLIP_EN undefined: the port is absent and there is no mirroring.

## Structure
- Shared package layer_pkg:
  - rgb_t typedef (logic [11:0]).
  - Screen constants SCREEN_W=640, SCREEN_H=480.
  - palette_lookup function (64-entry, 6-bit index → rgb_t).
- Sub-module rom_sprite:
  - Parametrised DEPTH and IDX_W=6.
  - Synchronous read, initialised from the sprite .mif file via ram_init_file.

## Test plan
- Reset held 2 cycles with arbitrary DrawX/DrawY → color=000, opaque=0 on all cycles until the first in-window pixel.
- cfg_we (100,50) then vsync_pulse; drive DrawX=100, DrawY=50 → 3 cycles later opaque reflects ROM word 0. Drive DrawX=99 → opaque=0. Drive DrawX=259 → ROM word 159. Drive DrawX=260 → opaque=0.
- cfg_we (300,0) with no vsync_pulse → window stays at (100,50). cfg_we and vsync_pulse in the same cycle → window moves immediately to the new value.
- FRAME_DIV=2, FRAMES=4, anim_en=1, 8 vsync pulses → frame sequence 0,0,1,1,2,2,3,3, then 0 after the 8th pulse. With anim_en=0, frame stays constant.
- ROM word whose index = TRANSP_IDX inside the window → opaque=0, color=000. Neighbouring index 5 → opaque=1 with the palette color.
- SPRITE_FLIP_EN, flip_h=1, position (100,50), DrawX=100 → ROM word X_SIZE−1 (159). At position (600,0), DrawX=639 → opaque=1; the sprite is clipped with no wrap to column 0.
